// File: rtl/uart_fifo_periph.sv
// FIFO-buffered UART peripheral on the core data bus: paced TX FIFO drained to a
// bench byte stream (or looped back into RX), RX FIFO filled from the bench.
module uart_fifo_periph #(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int TX_GAP   = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       addr,
  input  logic              req,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              gnt,
  output logic              rvalid,
  output logic              err,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              irq
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int TXC = TXA + 1;
  localparam int RXC = RXA + 1;
  localparam logic [7:0] GAP_LD = 8'(TX_GAP);

  localparam logic [1:0] REG_DATA = 2'b00;
  localparam logic [1:0] REG_RSVD = 2'b01;
  localparam logic [1:0] REG_STAT = 2'b10;
  localparam logic [1:0] REG_CTRL = 2'b11;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TXA-1:0]    tx_wr_ptr, tx_rd_ptr;
  logic [RXA-1:0]    rx_wr_ptr, rx_rd_ptr;
  logic [TXC-1:0]    tx_cnt;
  logic [RXC-1:0]    rx_cnt;
  logic [7:0]        gap;
  logic              loopback, rx_irq_en, tx_irq_en, tx_ovf;

  logic              tx_empty, tx_full, rx_nonempty, rx_full, tx_idle;
  logic [1:0]        sel;
  logic              wr_en, rd_en;
  logic              tx_push, tx_pop, rx_push, rx_pop, lb_push, tx_head_ok;
  logic              ovf_set, ovf_clr, ctrl_wr;
  logic [DATA_W-1:0] tx_head, rx_push_data;
  logic [31:0]       status, rdata_nxt;
  logic              err_nxt;
  logic              unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], be[3:1], wdata};

  assign tx_empty    = (tx_cnt == '0);
  assign tx_full     = (tx_cnt == TXC'(TX_DEPTH));
  assign rx_nonempty = (rx_cnt != '0);
  assign rx_full     = (rx_cnt == RXC'(RX_DEPTH));
  assign tx_idle     = tx_empty && (gap == 8'd0);
  assign tx_head     = tx_mem[tx_rd_ptr];

  assign sel   = addr[3:2];
  assign wr_en = req && we && be[0];
  assign rd_en = req && !we && be[0];
  assign gnt   = req;

  // Bus-side FIFO and register actions, all decided on pre-edge state.
  assign tx_push = wr_en && (sel == REG_DATA) && !tx_full;
  assign ovf_set = wr_en && (sel == REG_DATA) && tx_full;
  assign ovf_clr = wr_en && (sel == REG_STAT) && wdata[4];
  assign ctrl_wr = wr_en && (sel == REG_CTRL);
  assign rx_pop  = rd_en && (sel == REG_DATA) && rx_nonempty;

  // The TX head is offered either to the bench or, in loopback, straight to RX.
  assign tx_head_ok   = !tx_empty && (gap == 8'd0);
  assign tx_valid     = tx_head_ok && !loopback;
  assign tx_data      = tx_valid ? tx_head : '0;
  assign lb_push      = loopback && tx_head_ok && !rx_full;
  assign tx_pop       = lb_push || (tx_valid && tx_ready);
  assign rx_ready     = !rx_full && !loopback;
  assign rx_push      = lb_push || (rx_valid && rx_ready);
  assign rx_push_data = loopback ? tx_head : rx_data;

  assign irq = (rx_irq_en && rx_nonempty) || (tx_irq_en && tx_empty);

  assign status = {8'd0, 8'(tx_cnt), 8'(rx_cnt), 2'b00,
                   tx_idle, tx_ovf, tx_full, tx_empty, rx_full, rx_nonempty};

  always_comb begin
    rdata_nxt = 32'd0;
    err_nxt   = req && (sel == REG_RSVD);
    if (req && !we) begin
      case (sel)
        REG_DATA: if (rx_pop) rdata_nxt = 32'(rx_mem[rx_rd_ptr]);
        REG_STAT: rdata_nxt = status;
        REG_CTRL: rdata_nxt = {29'd0, tx_irq_en, rx_irq_en, loopback};
        default:  rdata_nxt = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= 32'd0;
    end else begin
      rvalid <= req;
      err    <= err_nxt;
      rdata  <= rdata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      loopback  <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        loopback  <= wdata[0];
        rx_irq_en <= wdata[1];
        tx_irq_en <= wdata[2];
      end
      if (ovf_set)      tx_ovf <= 1'b1;
      else if (ovf_clr) tx_ovf <= 1'b0;
    end
  end

  // Every pop reloads the gap counter, spacing pops TX_GAP+1 cycles apart.
  always_ff @(posedge clk) begin
    if (!resetn)           gap <= 8'd0;
    else if (tx_pop)       gap <= GAP_LD;
    else if (gap != 8'd0)  gap <= gap - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Storage is data-only; validity is carried entirely by the pointers and counts.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= wdata[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
  end

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed bench for uart_fifo_periph with default parameters (8-bit, depth 8, gap 3).
module tb_uart_fifo_periph;
  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        gnt, rvalid, err;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_fifo_periph dut (
    .clk(clk), .resetn(resetn), .addr(addr), .req(req), .we(we), .be(be),
    .wdata(wdata), .rdata(rdata), .gnt(gnt), .rvalid(rvalid), .err(err),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] rd, output logic e);
    @(negedge clk);
    addr = a; we = w; wdata = d; be = 4'h1; req = 1'b1;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk("rvalid", 32'(rvalid), 32'd1);
    rd = rdata;
    e  = err;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        e;
    bus(a, 1'b1, d, rd, e);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        e;
    bus(a, 1'b0, 32'd0, rd, e);
    chk(tag, rd, exp);
    chk({tag, "_err"}, 32'(e), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, t0, t1;
    logic [7:0] d0, d1;
    logic [31:0] rd;
    logic e;
    resetn = 1'b0; addr = '0; req = 1'b0; we = 1'b0; be = '0; wdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    t0 = 0; t1 = 0; d0 = '0; d1 = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Reset state
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    rd_chk("rst_status", 32'h8, 32'h0000_0024);

    // Two back-to-back TX writes, then paced drain
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'h1; addr = 32'h0; wdata = 32'h41;
    chk("gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    wdata = 32'h42;
    chk("b2b_rvalid0", 32'(rvalid), 32'd1);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk("b2b_rvalid1", 32'(rvalid), 32'd1);
    rd_chk("tx_cnt2", 32'h8, 32'h0002_0000);
    @(negedge clk);
    tx_ready = 1'b1;
    pc = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid) begin
        if (pc == 0) begin t0 = i; d0 = tx_data; end
        else if (pc == 1) begin t1 = i; d1 = tx_data; end
        pc++;
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("pop_count", 32'(pc), 32'd2);
    chk("pop0_data", 32'(d0), 32'h41);
    chk("pop1_data", 32'(d1), 32'h42);
    chk("pop_spacing", 32'(t1 - t0), 32'd4);
    rd_chk("tx_drained", 32'h8, 32'h0000_0024);

    // TX overflow and sticky flag clear
    for (int i = 0; i < 9; i++) wr(32'h0, 32'h10 + 32'(i));
    rd_chk("tx_full_ovf", 32'h8, 32'h0008_0018);
    wr(32'h8, 32'h10);
    rd_chk("ovf_clr", 32'h8, 32'h0008_0008);
    @(negedge clk);
    tx_ready = 1'b1;
    pc = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_valid) begin
        chk("drain_data", 32'(tx_data), 32'h10 + 32'(pc));
        pc++;
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("drain_count", 32'(pc), 32'd8);
    rd_chk("after_drain", 32'h8, 32'h0000_0024);

    // RX fill from bench, irq on rx_nonempty
    wr(32'hC, 32'h2);
    chk("irq_rx_empty", 32'(irq), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'hA0 + 8'(i);
      chk("rx_ready_fill", 32'(rx_ready), 32'd1);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    chk("rx_ready_full", 32'(rx_ready), 32'd0);
    chk("irq_rx_full", 32'(irq), 32'd1);
    rd_chk("rx_full_status", 32'h8, 32'h0000_0827);
    for (int i = 0; i < 8; i++) rd_chk("rx_read", 32'h0, 32'hA0 + 32'(i));
    rd_chk("rx_empty_read", 32'h0, 32'h0);
    chk("irq_rx_drained", 32'(irq), 32'd0);

    // Loopback, including stall with RX full
    wr(32'hC, 32'h1);
    wr(32'h0, 32'h55);
    chk("lb_tx_valid", 32'(tx_valid), 32'd0);
    repeat (2) @(negedge clk);
    rd_chk("lb_read", 32'h0, 32'h55);
    for (int i = 0; i < 8; i++) wr(32'h0, 32'h60 + 32'(i));
    repeat (40) @(negedge clk);
    wr(32'h0, 32'h68);
    repeat (10) @(negedge clk);
    chk("lb_stall_tx_valid", 32'(tx_valid), 32'd0);
    rd_chk("lb_stall_status", 32'h8, 32'h0001_0803);
    rd_chk("lb_first", 32'h0, 32'h60);
    repeat (10) @(negedge clk);
    rd_chk("lb_resume_status", 32'h8, 32'h0000_0827);
    for (int i = 1; i < 9; i++) rd_chk("lb_order", 32'h0, 32'h60 + 32'(i));

    // Reserved offset
    bus(32'h4, 1'b0, 32'h0, rd, e);
    chk("rsvd_rd_err", 32'(e), 32'd1);
    chk("rsvd_rd_data", rd, 32'h0);
    bus(32'h4, 1'b1, 32'hFF, rd, e);
    chk("rsvd_wr_err", 32'(e), 32'd1);
    rd_chk("rsvd_no_effect", 32'h8, 32'h0000_0024);
    rd_chk("ctrl_read", 32'hC, 32'h1);

    // Reset while TX is offering data and a response is pending
    wr(32'hC, 32'h2);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h77;
    @(negedge clk);
    rx_valid = 1'b0;
    wr(32'h0, 32'h1);
    wr(32'h0, 32'h2);
    chk("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'h1; addr = 32'h8; resetn = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    req = 1'b0; resetn = 1'b1; tx_ready = 1'b0;
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_err", 32'(err), 32'd0);
    chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_tx_data", 32'(tx_data), 32'd0);
    chk("rst_mid_rx_ready", 32'(rx_ready), 32'd1);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    rd_chk("rst_mid_status", 32'h8, 32'h0000_0024);
    rd_chk("rst_mid_ctrl", 32'hC, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
